audio_sample_feeder: RTL and testbench

Upstream stage of wbpwmaudio. Buffers bus-written PCM samples in a synchronous FIFO. Releases exactly one sample per programmable sample-rate tick to the PWM stage. Flags underrun and low fill so software can refill by interrupt, and holds the last sample on starvation to avoid clicks.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_sfifo.sv | 82 ++++++++
 rtl/audio_sample_feeder.sv | 107 ++++++++++
 tb/tb_audio_sample_feeder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the PWM audio path (sample feeder and wbpwmaudio).
//   AUDIO_DW             - sample width in bits (two's complement)
//   AUDIO_LGFIFO         - log2 of the sample FIFO depth
//   AUDIO_DEFAULT_RELOAD - reset reload value of the sample timer
//   sample_t             - one signed PCM sample
package audio_pkg;

  localparam int AUDIO_DW             = 16;
  localparam int AUDIO_LGFIFO         = 5;
  localparam int AUDIO_DEFAULT_RELOAD = 2082;

  typedef logic signed [AUDIO_DW-1:0] sample_t;

endpackage

// File: rtl/audio_sfifo.sv
// Synchronous sample FIFO with registered occupancy flags.
//   i_clk, i_reset  - clock, synchronous active-high reset (pointers and flags)
//   i_push, i_data  - enqueue request and data (ignored while full)
//   i_pop           - dequeue request (ignored while empty)
//   o_data          - current head of queue (valid while !o_empty)
//   o_fill          - number of stored entries
//   o_empty/o_full  - fill == 0 / fill == depth
//   o_half_empty    - fill <= depth/2
// All status outputs update on the edge that performs the push/pop.
module audio_sfifo
  import audio_pkg::*;
#(
  parameter int DW     = AUDIO_DW,
  parameter int LGFIFO = AUDIO_LGFIFO
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DW-1:0]     i_data,
  input  logic              i_pop,
  output logic [DW-1:0]     o_data,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_half_empty
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0]   FULL_FILL = (LGFIFO+1)'(DEPTH);
  localparam logic [LGFIFO:0]   HALF_FILL = (LGFIFO+1)'(DEPTH / 2);
  localparam logic [LGFIFO:0]   FILL_ONE  = 1;
  localparam logic [LGFIFO-1:0] PTR_ONE   = 1;

  logic [DW-1:0]     mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr;
  logic [LGFIFO-1:0] rd_ptr;
  logic [LGFIFO:0]   fill;
  logic [LGFIFO:0]   fill_next;
  logic              do_push;
  logic              do_pop;

  assign do_push = i_push && (fill != FULL_FILL);
  assign do_pop  = i_pop && (fill != '0);

  always_comb begin
    fill_next = fill;
    if (do_push && !do_pop)
      fill_next = fill + FILL_ONE;
    else if (!do_push && do_pop)
      fill_next = fill - FILL_ONE;
  end

  // Storage has no reset: contents are discarded simply by resetting the pointers.
  always_ff @(posedge i_clk) begin
    if (do_push)
      mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      o_empty      <= 1'b1;
      o_full       <= 1'b0;
      o_half_empty <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      fill         <= fill_next;
      o_empty      <= (fill_next == '0);
      o_full       <= (fill_next == FULL_FILL);
      o_half_empty <= (fill_next <= HALF_FILL);
    end
  end

  assign o_data = mem[rd_ptr];
  assign o_fill = fill;

endmodule

// File: rtl/audio_sample_feeder.sv
// Upstream stage of wbpwmaudio: buffers bus-written PCM samples and releases
// one per sample-timer tick to the PWM stage.
//   i_clk, i_reset        - clock, synchronous active-high reset
//   i_wr, i_wdata         - sample write; accepted when i_wr && o_wr_ready
//   o_wr_ready            - FIFO not full
//   i_enable              - playback enable (timer runs only while high)
//   i_timer_load/_val     - load a new reload value (0 is clamped to 1)
//   i_clr_underrun        - clear the sticky underrun flag
//   o_sample, o_sample_stb- current sample and one-cycle "new sample" pulse
//   o_fill/o_empty/o_half_empty - FIFO occupancy (registered)
//   o_underrun            - sticky: a tick found the FIFO empty
// Tick period is reload+1 cycles. On starvation o_sample holds its last value.
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int DW             = AUDIO_DW,
  parameter int LGFIFO         = AUDIO_LGFIFO,
  parameter int LGTIMER        = 16,
  parameter int DEFAULT_RELOAD = AUDIO_DEFAULT_RELOAD
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [DW-1:0]      i_wdata,
  output logic               o_wr_ready,
  input  logic               i_enable,
  input  logic               i_timer_load,
  input  logic [LGTIMER-1:0] i_timer_val,
  input  logic               i_clr_underrun,
  output logic [DW-1:0]      o_sample,
  output logic               o_sample_stb,
  output logic [LGFIFO:0]    o_fill,
  output logic               o_empty,
  output logic               o_half_empty,
  output logic               o_underrun
);

  localparam logic [LGTIMER-1:0] RELOAD_RST = LGTIMER'(DEFAULT_RELOAD);
  localparam logic [LGTIMER-1:0] RELOAD_MIN = 1;

  logic [LGTIMER-1:0] reload;
  logic [LGTIMER-1:0] counter;
  logic [LGTIMER-1:0] load_val;
  logic               tick;
  logic               pop;
  logic               push;
  logic               fifo_full;
  logic [DW-1:0]      fifo_head;

  assign load_val = (i_timer_val == '0) ? RELOAD_MIN : i_timer_val;

  // A load cycle never ticks, even if the old count had reached zero.
  assign tick = i_enable && !i_timer_load && (counter == '0);
  assign pop  = tick && !o_empty;
  // Registered full flag is exactly (o_fill == depth), so a write coinciding
  // with a pop from a full FIFO is still rejected.
  assign o_wr_ready = !fifo_full;
  assign push       = i_wr && o_wr_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      reload  <= RELOAD_RST;
      counter <= RELOAD_RST;
    end else if (i_timer_load) begin
      reload  <= load_val;
      counter <= load_val;
    end else if (!i_enable || (counter == '0)) begin
      counter <= reload;
    end else begin
      counter <= counter - RELOAD_MIN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_sample     <= '0;
      o_sample_stb <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_sample_stb <= pop;
      if (pop)
        o_sample <= fifo_head;
      // Set has priority over a coincident clear.
      if (tick && o_empty)
        o_underrun <= 1'b1;
      else if (i_clr_underrun)
        o_underrun <= 1'b0;
    end
  end

  audio_sfifo #(
    .DW     (DW),
    .LGFIFO (LGFIFO)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (push),
    .i_data       (i_wdata),
    .i_pop        (pop),
    .o_data       (fifo_head),
    .o_fill       (o_fill),
    .o_empty      (o_empty),
    .o_full       (fifo_full),
    .o_half_empty (o_half_empty)
  );

endmodule

// File: tb/tb_audio_sample_feeder.sv
module tb_audio_sample_feeder;
  import audio_pkg::*;

  localparam int RST_PERIOD = 2083;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_wr = 1'b0;
  logic [15:0] i_wdata = '0;
  logic        o_wr_ready;
  logic        i_enable = 1'b0;
  logic        i_timer_load = 1'b0;
  logic [15:0] i_timer_val = '0;
  logic        i_clr_underrun = 1'b0;
  logic [15:0] o_sample;
  logic        o_sample_stb;
  logic [5:0]  o_fill;
  logic        o_empty;
  logic        o_half_empty;
  logic        o_underrun;

  int checks = 0;
  int errors = 0;
  sample_t sb[$];

  always #5 clk = ~clk;

  audio_sample_feeder #(
    .DW             (16),
    .LGFIFO         (5),
    .LGTIMER        (16),
    .DEFAULT_RELOAD (2082)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_wr           (i_wr),
    .i_wdata        (i_wdata),
    .o_wr_ready     (o_wr_ready),
    .i_enable       (i_enable),
    .i_timer_load   (i_timer_load),
    .i_timer_val    (i_timer_val),
    .i_clr_underrun (i_clr_underrun),
    .o_sample       (o_sample),
    .o_sample_stb   (o_sample_stb),
    .o_fill         (o_fill),
    .o_empty        (o_empty),
    .o_half_empty   (o_half_empty),
    .o_underrun     (o_underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until a strobe (or the underrun flag) is seen, bounded by max_cycles.
  task automatic wait_for(input bit on_underrun, input int max_cycles,
                          output int cycles, output bit timed_out, output bit saw_stb);
    cycles = 0;
    timed_out = 1'b1;
    saw_stb = 1'b0;
    while (cycles < max_cycles) begin
      step();
      cycles++;
      if (o_sample_stb) saw_stb = 1'b1;
      if (on_underrun ? o_underrun : o_sample_stb) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic write_sample(input sample_t v);
    i_wr = 1'b1;
    i_wdata = v;
    if (sb.size() < 32) sb.push_back(v);
    step();
    i_wr = 1'b0;
  endtask

  task automatic load_reload(input logic [15:0] v);
    i_timer_load = 1'b1;
    i_timer_val = v;
    step();
    i_timer_load = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(); step();
    i_reset = 1'b0;
    repeat (5) step();
    checks += 7;
    if (o_sample !== 16'h0) begin errors++; $display("FAIL rst_sample got %h exp 0000", o_sample); end
    if (o_sample_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %b exp 0", o_sample_stb); end
    if (o_fill !== 6'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", o_fill); end
    if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", o_empty); end
    if (o_half_empty !== 1'b1) begin errors++; $display("FAIL rst_half got %b exp 1", o_half_empty); end
    if (o_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", o_underrun); end
    if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b exp 1", o_wr_ready); end
  endtask

  task automatic test_playback();
    int cyc; bit to, s;
    sample_t exp;
    i_enable = 1'b0;
    write_sample(16'h1111);
    write_sample(16'h2222);
    write_sample(16'h3333);
    checks++;
    if (o_fill !== 6'd3) begin errors++; $display("FAIL play_fill3 got %0d exp 3", o_fill); end
    load_reload(16'd9);
    i_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(1'b0, 15, cyc, to, s);
      checks++;
      if (to) begin
        errors++; $display("FAIL play_stb%0d got timeout exp strobe", k);
      end else begin
        if (cyc !== 10) begin errors++; $display("FAIL play_gap%0d got %0d exp 10", k, cyc); end
        exp = sb.pop_front();
        checks += 2;
        if (o_sample !== exp) begin errors++; $display("FAIL play_sample%0d got %h exp %h", k, o_sample, exp); end
        if (o_fill !== 6'(2 - k)) begin errors++; $display("FAIL play_fill%0d got %0d exp %0d", k, o_fill, 2 - k); end
      end
    end
  endtask

  task automatic test_underrun();
    int cyc; bit to, s;
    wait_for(1'b1, 15, cyc, to, s);
    checks += 4;
    if (to) begin errors++; $display("FAIL urun_set got timeout exp underrun"); end
    if (cyc !== 10) begin errors++; $display("FAIL urun_gap got %0d exp 10", cyc); end
    if (s) begin errors++; $display("FAIL urun_nostb got strobe exp none"); end
    if (o_sample !== 16'h3333) begin errors++; $display("FAIL urun_hold got %h exp 3333", o_sample); end
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
    checks++;
    if (o_underrun !== 1'b0) begin errors++; $display("FAIL urun_clear got %b exp 0", o_underrun); end
    repeat (8) step();
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
    checks += 2;
    if (o_underrun !== 1'b1) begin errors++; $display("FAIL urun_set_wins got %b exp 1", o_underrun); end
    if (o_sample_stb !== 1'b0) begin errors++; $display("FAIL urun_set_wins_stb got %b exp 0", o_sample_stb); end
    i_enable = 1'b0;
    step();
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
  endtask

  task automatic test_full();
    int cyc; bit to, s;
    sample_t exp;
    for (int i = 0; i < 33; i++) begin
      write_sample(sample_t'(i));
      if (i == 30) begin
        checks++;
        if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready31 got %b exp 1", o_wr_ready); end
      end
      if (i == 31) begin
        checks++;
        if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready32 got %b exp 0", o_wr_ready); end
      end
    end
    checks += 3;
    if (o_fill !== 6'd32) begin errors++; $display("FAIL full_fill got %0d exp 32", o_fill); end
    if (o_half_empty !== 1'b0) begin errors++; $display("FAIL full_half got %b exp 0", o_half_empty); end
    if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", o_wr_ready); end
    i_enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      wait_for(1'b0, 15, cyc, to, s);
      checks++;
      if (to) begin
        errors++; $display("FAIL full_stb%0d got timeout exp strobe", k);
      end else begin
        exp = sb.pop_front();
        if (o_sample !== exp) begin errors++; $display("FAIL full_sample%0d got %h exp %h", k, o_sample, exp); end
      end
    end
    wait_for(1'b1, 15, cyc, to, s);
    checks += 3;
    if (to) begin errors++; $display("FAIL full_drain_urun got timeout exp underrun"); end
    if (s) begin errors++; $display("FAIL full_dropped got strobe %h exp none", o_sample); end
    if (o_empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b exp 1", o_empty); end
    i_enable = 1'b0;
    step();
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
  endtask

  task automatic test_back_to_back();
    sample_t exp;
    write_sample(16'hAAAA);
    i_enable = 1'b1;
    repeat (9) step();
    i_wr = 1'b1; i_wdata = 16'hBBBB; sb.push_back(16'hBBBB);
    step();
    i_wr = 1'b0;
    exp = sb.pop_front();
    checks += 3;
    if (o_sample_stb !== 1'b1) begin errors++; $display("FAIL b2b_stb got %b exp 1", o_sample_stb); end
    if (o_sample !== exp) begin errors++; $display("FAIL b2b_sample got %h exp %h", o_sample, exp); end
    if (o_fill !== 6'd1) begin errors++; $display("FAIL b2b_fill got %0d exp 1", o_fill); end
    repeat (10) step();
    exp = sb.pop_front();
    checks += 3;
    if (o_sample_stb !== 1'b1) begin errors++; $display("FAIL b2b_stb2 got %b exp 1", o_sample_stb); end
    if (o_sample !== exp) begin errors++; $display("FAIL b2b_sample2 got %h exp %h", o_sample, exp); end
    if (o_fill !== 6'd0) begin errors++; $display("FAIL b2b_fill2 got %0d exp 0", o_fill); end
    repeat (9) step();
    i_wr = 1'b1; i_wdata = 16'hCCCC; sb.push_back(16'hCCCC);
    step();
    i_wr = 1'b0;
    checks += 4;
    if (o_underrun !== 1'b1) begin errors++; $display("FAIL b2b_empty_urun got %b exp 1", o_underrun); end
    if (o_sample_stb !== 1'b0) begin errors++; $display("FAIL b2b_empty_stb got %b exp 0", o_sample_stb); end
    if (o_fill !== 6'd1) begin errors++; $display("FAIL b2b_empty_fill got %0d exp 1", o_fill); end
    if (o_sample !== 16'hBBBB) begin errors++; $display("FAIL b2b_empty_hold got %h exp bbbb", o_sample); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to, s;
    sample_t exp;
    i_enable = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    sb.delete();
    load_reload(16'd9);
    for (int i = 0; i < 10; i++) write_sample(sample_t'(16'h0100 + i));
    i_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_for(1'b0, 15, cyc, to, s);
      checks++;
      if (to) begin
        errors++; $display("FAIL mid_stb%0d got timeout exp strobe", k);
      end else begin
        exp = sb.pop_front();
        if (o_sample !== exp) begin errors++; $display("FAIL mid_sample%0d got %h exp %h", k, o_sample, exp); end
      end
    end
    repeat (4) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    sb.delete();
    checks += 7;
    if (o_sample !== 16'h0) begin errors++; $display("FAIL mid_rst_sample got %h exp 0000", o_sample); end
    if (o_sample_stb !== 1'b0) begin errors++; $display("FAIL mid_rst_stb got %b exp 0", o_sample_stb); end
    if (o_fill !== 6'd0) begin errors++; $display("FAIL mid_rst_fill got %0d exp 0", o_fill); end
    if (o_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b exp 1", o_empty); end
    if (o_half_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_half got %b exp 1", o_half_empty); end
    if (o_underrun !== 1'b0) begin errors++; $display("FAIL mid_rst_urun got %b exp 0", o_underrun); end
    if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", o_wr_ready); end
    wait_for(1'b1, RST_PERIOD + 20, cyc, to, s);
    checks += 3;
    if (to) begin errors++; $display("FAIL mid_first_tick got timeout exp underrun"); end
    if (cyc !== RST_PERIOD) begin errors++; $display("FAIL mid_first_gap got %0d exp %0d", cyc, RST_PERIOD); end
    if (s) begin errors++; $display("FAIL mid_first_stb got strobe exp none"); end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_underrun();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
